marcador_rastro: RTL

Trail marker and collision checker that sits directly downstream of the player movement blocks and upstream of the trail RAM. Each time a player advances one 8x8 step it hands its new head pixel coordinate here. The block converts it to a cell address on an 80x60 grid and checks it against the arena border and the RAM contents. It then either records the cell as that player's trail or raises that player's sticky collision flag. It also owns clearing the trail RAM after reset and on `reiniciar`.

---
 rtl/marcador_rastro_pkg.sv | 38 +++
 rtl/marcador_rastro_if.sv | 21 ++
 rtl/marcador_rastro_celula_endereco.sv | 32 +++
 rtl/marcador_rastro.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/marcador_rastro_pkg.sv
// Shared grid geometry, cell codes and FSM encoding for the trail marker,
// the player movement blocks and the pixel renderer.
package marcador_rastro_pkg;

  localparam int unsigned GRID_W  = 80;
  localparam int unsigned GRID_H  = 60;
  localparam int unsigned BORDA   = 2;
  localparam int unsigned RAM_LAT = 2;

  localparam int unsigned PIX_W  = 10;
  localparam int unsigned CEL_W  = 7;
  localparam int unsigned END_W  = 13;
  localparam int unsigned DADO_W = 2;

  localparam logic [DADO_W-1:0] VAZIO = 2'd0;
  localparam logic [DADO_W-1:0] J1    = 2'd1;
  localparam logic [DADO_W-1:0] J2    = 2'd2;

  typedef enum logic [2:0] {
    LIMPA    = 3'd0,
    OCIOSO   = 3'd1,
    CONSULTA = 3'd2,
    ESPERA   = 3'd3,
    DECIDE   = 3'd4,
    ESCREVE  = 3'd5
  } estado_t;

  // Request fields kept between acceptance and the collision decision.
  typedef struct packed {
    logic jogador;
    logic borda;
  } pedido_t;

  function automatic logic [DADO_W-1:0] codigo_jogador(input logic jogador);
    return jogador ? J2 : J1;
  endfunction

endpackage

// File: rtl/marcador_rastro_if.sv
// Move-request handshake from the player blocks and the trail RAM port.
interface marcador_rastro_mov_if;
  logic       mov_valid;
  logic       mov_jogador;
  logic [9:0] mov_x;
  logic [9:0] mov_y;
  logic       mov_ready;

  modport master (output mov_valid, mov_jogador, mov_x, mov_y, input mov_ready);
  modport slave  (input mov_valid, mov_jogador, mov_x, mov_y, output mov_ready);
endinterface

interface marcador_rastro_ram_if;
  logic [12:0] ram_endereco;
  logic        ram_wren;
  logic [1:0]  ram_dado;
  logic [1:0]  ram_q;

  modport master (output ram_endereco, ram_wren, ram_dado, input ram_q);
  modport slave  (input ram_endereco, ram_wren, ram_dado, output ram_q);
endinterface

// File: rtl/marcador_rastro_celula_endereco.sv
// Pixel coordinate to grid cell, linear RAM address and arena-border flag.
module celula_endereco #(
  parameter int unsigned GRID_W = marcador_rastro_pkg::GRID_W,
  parameter int unsigned GRID_H = marcador_rastro_pkg::GRID_H,
  parameter int unsigned BORDA  = marcador_rastro_pkg::BORDA
) (
  input  logic [marcador_rastro_pkg::PIX_W-1:0] x,
  input  logic [marcador_rastro_pkg::PIX_W-1:0] y,
  output logic [marcador_rastro_pkg::CEL_W-1:0] cx_c,
  output logic [marcador_rastro_pkg::CEL_W-1:0] cy_c,
  output logic [marcador_rastro_pkg::END_W-1:0] endereco_c,
  output logic                                  borda_c
);
  import marcador_rastro_pkg::*;

  logic fora_c;

  assign cx_c = x[PIX_W-1:3];
  assign cy_c = y[PIX_W-1:3];

  // Off-screen pixels also land outside the arena.
  assign fora_c = (x >= PIX_W'(GRID_W * 8)) || (y >= PIX_W'(GRID_H * 8));

  assign borda_c = fora_c
                || (cx_c <  CEL_W'(BORDA))
                || (cx_c >= CEL_W'(GRID_W - BORDA))
                || (cy_c <  CEL_W'(BORDA))
                || (cy_c >= CEL_W'(GRID_H - BORDA));

  assign endereco_c = END_W'(cy_c) * END_W'(GRID_W) + END_W'(cx_c);

endmodule

// File: rtl/marcador_rastro.sv
// Trail marker: clears the trail RAM, then records each player step or raises
// that player's sticky collision flag on a border hit or occupied cell.
module marcador_rastro #(
  parameter int unsigned GRID_W  = marcador_rastro_pkg::GRID_W,
  parameter int unsigned GRID_H  = marcador_rastro_pkg::GRID_H,
  parameter int unsigned BORDA   = marcador_rastro_pkg::BORDA,
  parameter int unsigned RAM_LAT = marcador_rastro_pkg::RAM_LAT
) (
  input  logic                        VGA_CLK,
  input  logic                        reset_n,
  input  logic                        reiniciar,
  marcador_rastro_mov_if.slave        mov,
  marcador_rastro_ram_if.master       ram,
  output logic                        colisao_p1,
  output logic                        colisao_p2,
  output logic                        limpando
);
  import marcador_rastro_pkg::*;

  localparam int unsigned CELULAS = GRID_W * GRID_H;
  localparam int unsigned CNT_W   = (RAM_LAT > 2) ? $clog2(RAM_LAT) : 1;

  estado_t             estado, estado_d;
  logic [END_W-1:0]    varre, varre_d;
  logic [CNT_W-1:0]    espera, espera_d;
  pedido_t             pedido, pedido_d;
  logic [END_W-1:0]    endereco, endereco_d;
  logic                wren, wren_d;
  logic [DADO_W-1:0]   dado, dado_d;
  logic                pronto, pronto_d;
  logic                col1, col1_d;
  logic                col2, col2_d;
  logic                limp, limp_d;

  logic [CEL_W-1:0]    cx_unused, cy_unused;
  logic [END_W-1:0]    endereco_c;
  logic                borda_c;
  logic                aceita_c;
  logic                ja_colidiu_c;
  logic                pedido_colidiu_c;

  celula_endereco #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .BORDA  (BORDA)
  ) u_celula (
    .x          (mov.mov_x),
    .y          (mov.mov_y),
    .cx_c       (cx_unused),
    .cy_c       (cy_unused),
    .endereco_c (endereco_c),
    .borda_c    (borda_c)
  );

  assign aceita_c         = mov.mov_valid && pronto;
  assign ja_colidiu_c     = mov.mov_jogador ? col2 : col1;
  assign pedido_colidiu_c = pedido.jogador ? col2 : col1;

  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      estado   <= LIMPA;
      varre    <= '0;
      espera   <= '0;
      pedido   <= '0;
      endereco <= '0;
      wren     <= 1'b0;
      dado     <= VAZIO;
      pronto   <= 1'b0;
      col1     <= 1'b0;
      col2     <= 1'b0;
      limp     <= 1'b1;
    end else begin
      estado   <= estado_d;
      varre    <= varre_d;
      espera   <= espera_d;
      pedido   <= pedido_d;
      endereco <= endereco_d;
      wren     <= wren_d;
      dado     <= dado_d;
      pronto   <= pronto_d;
      col1     <= col1_d;
      col2     <= col2_d;
      limp     <= limp_d;
    end
  end

  // Outputs are computed one cycle ahead and registered with the state.
  always_comb begin
    estado_d   = estado;
    varre_d    = varre;
    espera_d   = espera;
    pedido_d   = pedido;
    endereco_d = endereco;
    wren_d     = 1'b0;
    dado_d     = VAZIO;
    pronto_d   = 1'b0;
    col1_d     = col1;
    col2_d     = col2;
    limp_d     = 1'b0;

    unique case (estado)
      LIMPA: begin
        endereco_d = varre;
        wren_d     = 1'b1;
        limp_d     = 1'b1;
        varre_d    = varre + END_W'(1);
        if (varre == END_W'(CELULAS - 1)) estado_d = OCIOSO;
      end
      OCIOSO: begin
        pronto_d = 1'b1;
        if (aceita_c) begin
          pronto_d = 1'b0;
          pedido_d = '{jogador: mov.mov_jogador, borda: borda_c};
          estado_d = CONSULTA;
          // Only real lookups move the RAM address.
          if (!borda_c && !ja_colidiu_c) endereco_d = endereco_c;
        end
      end
      CONSULTA: begin
        espera_d = '0;
        if (pedido_colidiu_c) begin
          estado_d = OCIOSO;
          pronto_d = 1'b1;
        end else if (pedido.borda) begin
          if (pedido.jogador) col2_d = 1'b1;
          else                col1_d = 1'b1;
          estado_d = OCIOSO;
          pronto_d = 1'b1;
        end else begin
          estado_d = (RAM_LAT > 1) ? ESPERA : DECIDE;
        end
      end
      ESPERA: begin
        espera_d = espera + CNT_W'(1);
        if (espera == CNT_W'(RAM_LAT - 2)) estado_d = DECIDE;
      end
      DECIDE: begin
        if (ram.ram_q != VAZIO) begin
          if (pedido.jogador) col2_d = 1'b1;
          else                col1_d = 1'b1;
          estado_d = OCIOSO;
          pronto_d = 1'b1;
        end else begin
          wren_d   = 1'b1;
          dado_d   = codigo_jogador(pedido.jogador);
          estado_d = ESCREVE;
        end
      end
      ESCREVE: begin
        estado_d = OCIOSO;
        pronto_d = 1'b1;
      end
      default: begin
        estado_d = LIMPA;
        varre_d  = '0;
        limp_d   = 1'b1;
      end
    endcase

    // Restart overrides everything, including an in-flight request.
    if (reiniciar) begin
      estado_d   = LIMPA;
      varre_d    = '0;
      espera_d   = '0;
      endereco_d = '0;
      wren_d     = 1'b0;
      dado_d     = VAZIO;
      pronto_d   = 1'b0;
      col1_d     = 1'b0;
      col2_d     = 1'b0;
      limp_d     = 1'b1;
    end
  end

  assign mov.mov_ready    = pronto;
  assign ram.ram_endereco = endereco;
  assign ram.ram_wren     = wren;
  assign ram.ram_dado     = dado;
  assign colisao_p1       = col1;
  assign colisao_p2       = col2;
  assign limpando         = limp;

endmodule
